gs_ct_butterfly_pipe: RTL and testbench

Pipelined radix-2 butterfly for the Kyber polynomial-multiplier datapath (q = 3329, 12-bit coefficients). It computes either a Cooley-Tukey (forward NTT) or a Gentleman-Sande (inverse NTT) butterfly per issued coefficient pair. It sits directly upstream of the per-lane divide-by-two units: in GS mode its two outputs feed those units, which apply the 1/2 scaling of the inverse transform. Fixed 4-cycle latency, one butterfly per cycle, per-item mode tag, global stall.

---
 rtl/kyber_pkg.sv | 36 +++
 rtl/barrett_red.sv | 39 +++
 rtl/gs_ct_butterfly_pipe.sv | 110 +++++++++++
 tb/tb_gs_ct_butterfly_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants, types and modular add/sub helpers
// used by the butterfly datapath.
package kyber_pkg;

    localparam int unsigned Q         = 3329;
    localparam int unsigned BARRETT_M = 5039;
    localparam int unsigned COEF_W    = 12;
    localparam int unsigned PROD_W    = 24;
    localparam int unsigned LAT       = 4;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;

    // Operands are in [0, Q), so one conditional correction is enough.
    function automatic coef_t mod_add(input coef_t x, input coef_t y);
        logic [12:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= 13'(Q)) begin
            s = s - 13'(Q);
        end
        return s[11:0];
    endfunction

    function automatic coef_t mod_sub(input coef_t x, input coef_t y);
        logic [12:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[12]) begin
            d = d + 13'(Q);
        end
        return d[11:0];
    endfunction

endpackage

// File: rtl/barrett_red.sv
// Barrett reduction of a 24-bit product: the quotient estimate and partial
// remainder are registered (stage 3), and the final corrections are combinational (stage 4).
module barrett_red
    import kyber_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en_i,
    input  prod_t p_i,
    output coef_t res_o
);

    logic [36:0] mul;
    logic [12:0] t;
    logic [13:0] r_d;
    logic [13:0] r_q;
    logic [13:0] c1;

    // The quotient estimate is never too large, so r = p - t*Q lies in [0, 3Q) and fits in 14 bits.
    always_comb begin
        mul = 37'(p_i) * 37'(BARRETT_M);
        t   = 13'(mul >> PROD_W);
        r_d = 14'(p_i - 24'(t) * 24'(Q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= r_d;
        end
    end

    always_comb begin
        c1    = (r_q >= 14'(Q)) ? (r_q - 14'(Q)) : r_q;
        res_o = (c1 >= 14'(Q)) ? 12'(c1 - 14'(Q)) : 12'(c1);
    end

endmodule

// File: rtl/gs_ct_butterfly_pipe.sv
// Four-stage Cooley-Tukey / Gentleman-Sande butterfly for q = 3329 with
// a per-item mode tag and a global stall that freezes every register.
module gs_ct_butterfly_pipe
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        in_valid,
    input  logic        mode,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] w,
    output logic        out_valid,
    output logic        out_mode,
    output logic [11:0] u,
    output logic [11:0] v
);

    logic  s1_valid_q, s1_mode_q;
    coef_t s1_pass_q, s1_m_q, s1_w_q;
    coef_t s1_pass_d, s1_m_d;

    logic  s2_valid_q, s2_mode_q;
    coef_t s2_pass_q;
    prod_t s2_p_q, s2_p_d;

    logic  s3_valid_q, s3_mode_q;
    coef_t s3_pass_q;
    coef_t red;

    logic  out_valid_q, out_mode_q;
    coef_t u_q, v_q, u_d, v_d;

    logic  en;

    assign en = !stall;

    // GS folds the add/sub into stage 1 so the multiplier only ever sees (m, w).
    always_comb begin
        s1_pass_d = a;
        s1_m_d    = b;
        if (mode == MODE_GS) begin
            s1_pass_d = mod_add(a, b);
            s1_m_d    = mod_sub(a, b);
        end
        s2_p_d = 24'(s1_m_q) * 24'(s1_w_q);
    end

    always_comb begin
        u_d = s3_pass_q;
        v_d = red;
        if (s3_mode_q == MODE_CT) begin
            u_d = mod_add(s3_pass_q, red);
            v_d = mod_sub(s3_pass_q, red);
        end
    end

    barrett_red u_barrett_red (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .p_i   (s2_p_q),
        .res_o (red)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_pass_q   <= '0;
            s1_m_q      <= '0;
            s1_w_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_pass_q   <= '0;
            s2_p_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_mode_q   <= 1'b0;
            s3_pass_q   <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
            u_q         <= '0;
            v_q         <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s1_mode_q   <= mode;
            s1_pass_q   <= s1_pass_d;
            s1_m_q      <= s1_m_d;
            s1_w_q      <= w;
            s2_valid_q  <= s1_valid_q;
            s2_mode_q   <= s1_mode_q;
            s2_pass_q   <= s1_pass_q;
            s2_p_q      <= s2_p_d;
            s3_valid_q  <= s2_valid_q;
            s3_mode_q   <= s2_mode_q;
            s3_pass_q   <= s2_pass_q;
            out_valid_q <= s3_valid_q;
            out_mode_q  <= s3_mode_q;
            u_q         <= u_d;
            v_q         <= v_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign u         = u_q;
    assign v         = v_q;

endmodule

// File: tb/tb_gs_ct_butterfly_pipe.sv
// Scoreboard bench for gs_ct_butterfly_pipe: directed butterflies, stall,
// mid-flight reset and a randomised run against a behavioural model.
module tb_gs_ct_butterfly_pipe;

    localparam int QM = 3329;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] a = '0;
    logic [11:0] b = '0;
    logic [11:0] w = '0;
    logic        out_valid;
    logic        out_mode;
    logic [11:0] u;
    logic [11:0] v;

    int checks = 0;
    int failures = 0;
    int tot_cnt = 0;
    int run_cnt = 0;
    logic last_stalled = 1'b0;

    logic [24:0] exp_q[$];
    int          run_q[$];
    int          tot_q[$];
    int          lat_q[$];

    gs_ct_butterfly_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .in_valid  (in_valid),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .w         (w),
        .out_valid (out_valid),
        .out_mode  (out_mode),
        .u         (u),
        .v         (v)
    );

    // clock / edge bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        tot_cnt <= tot_cnt + 1;
        if (!stall) run_cnt <= run_cnt + 1;
        last_stalled <= stall;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // monitor / scoreboard
    logic [25:0] snap;
    logic        snap_vld = 1'b0;
    logic [24:0] m_exp;
    int          m_run, m_tot, m_lat;

    always @(negedge clk) begin
        if (rst_n) begin
            if (last_stalled && snap_vld) begin
                chk("stall_hold", 32'({out_valid, out_mode, u, v}), 32'(snap));
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    m_exp = exp_q.pop_front();
                    m_run = run_q.pop_front();
                    m_tot = tot_q.pop_front();
                    m_lat = lat_q.pop_front();
                    chk("result", 32'({out_mode, u, v}), 32'(m_exp));
                    chk("latency_run", run_cnt - m_run, 32'd4);
                    if (m_lat > 0) chk("latency_total", tot_cnt - m_tot, m_lat);
                end
            end
            snap     = {out_valid, out_mode, u, v};
            snap_vld = 1'b1;
        end else begin
            snap_vld = 1'b0;
        end
    end

    // driver tasks
    task automatic issue(input logic m, input logic [11:0] ia, input logic [11:0] ib,
                         input logic [11:0] iw, input logic [11:0] eu, input logic [11:0] ev,
                         input int lat);
        mode = m; a = ia; b = ib; w = iw; in_valid = 1'b1;
        exp_q.push_back({m, eu, ev});
        run_q.push_back(run_cnt);
        tot_q.push_back(tot_cnt);
        lat_q.push_back(lat);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [24:0] model(input logic m, input int ia, input int ib, input int iw);
        int bw, eu, ev;
        if (!m) begin
            bw = (ib * iw) % QM;
            eu = (ia + bw) % QM;
            ev = (ia - bw + QM) % QM;
        end else begin
            eu = (ia + ib) % QM;
            ev = (((ia - ib + QM) % QM) * iw) % QM;
        end
        return {m, 12'(eu), 12'(ev)};
    endfunction

    logic [24:0] r_exp;
    logic        r_m;
    logic [11:0] r_a, r_b, r_w;

    initial begin
        // reset state
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_mode", 32'(out_mode), 32'd0);
        chk("reset_u", 32'(u), 32'd0);
        chk("reset_v", 32'(v), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // directed CT / GS vectors
        issue(1'b0, 12'd100, 12'd2, 12'd17, 12'd134, 12'd66, 4);
        idle(6);
        issue(1'b0, 12'd3328, 12'd1, 12'd1, 12'd0, 12'd3327, 4);
        issue(1'b0, 12'd0, 12'd3328, 12'd3328, 12'd1, 12'd3328, 4);
        idle(6);
        issue(1'b1, 12'd5, 12'd3, 12'd2, 12'd8, 12'd4, 4);
        issue(1'b1, 12'd0, 12'd1, 12'd3328, 12'd1, 12'd1, 4);
        idle(6);
        issue(1'b0, 12'd3328, 12'd3328, 12'd1, 12'd3327, 12'd0, 4);
        issue(1'b1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 4);
        idle(6);

        // back-to-back mixed modes
        issue(1'b0, 12'd100, 12'd2, 12'd17, 12'd134, 12'd66, 4);
        issue(1'b1, 12'd5, 12'd3, 12'd2, 12'd8, 12'd4, 4);
        idle(6);

        // stall after the second issue; in_valid under stall must be ignored
        issue(1'b0, 12'd1000, 12'd2000, 12'd3, 12'd342, 12'd1658, 9);
        issue(1'b1, 12'd3000, 12'd500, 12'd10, 12'd171, 12'd1697, 9);
        stall = 1'b1; in_valid = 1'b1; mode = 1'b1; a = 12'd1; b = 12'd2; w = 12'd3;
        idle(5);
        stall = 1'b0; in_valid = 1'b0;
        issue(1'b0, 12'd7, 12'd0, 12'd1234, 12'd7, 12'd7, 4);
        idle(8);

        // reset mid-flight: first item is on the outputs when reset hits
        issue(1'b0, 12'd100, 12'd2, 12'd17, 12'd134, 12'd66, 4);
        issue(1'b1, 12'd5, 12'd3, 12'd2, 12'd8, 12'd4, 4);
        issue(1'b0, 12'd3328, 12'd1, 12'd1, 12'd0, 12'd3327, 4);
        issue(1'b1, 12'd0, 12'd1, 12'd3328, 12'd1, 12'd1, 4);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_u", 32'(u), 32'd0);
        chk("async_reset_v", 32'(v), 32'd0);
        chk("async_reset_mode", 32'(out_mode), 32'd0);
        exp_q.delete(); run_q.delete(); tot_q.delete(); lat_q.delete();
        #1 rst_n = 1'b1;
        idle(8);
        chk("no_emerge", 32'(out_valid), 32'd0);
        issue(1'b1, 12'd5, 12'd3, 12'd2, 12'd8, 12'd4, 4);
        idle(6);

        // randomised run with random stalls and gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                stall = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                a = 12'($urandom_range(0, QM - 1));
                idle(1);
                stall = 1'b0;
                in_valid = 1'b0;
            end else if ($urandom_range(0, 3) != 0) begin
                r_m = 1'($urandom_range(0, 1));
                r_a = 12'($urandom_range(0, QM - 1));
                r_b = 12'($urandom_range(0, QM - 1));
                r_w = 12'($urandom_range(0, QM - 1));
                r_exp = model(r_m, int'(r_a), int'(r_b), int'(r_w));
                issue(r_m, r_a, r_b, r_w, r_exp[23:12], r_exp[11:0], 0);
            end else begin
                idle(1);
            end
        end

        // bounded drain
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
